// File: rtl/ndma_pkg.sv
// Shared definitions for the NDMA transfer controller.
//   NdmaLenW      : default width of the transfer word count
//   NdmaWordBytes : default address stride per word, in bytes
//   ndma_state_e  : controller FSM states
package ndma_pkg;

  localparam int unsigned NdmaLenW      = 16;
  localparam int unsigned NdmaWordBytes = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdWait,
    StWrIssue,
    StWrWait,
    StDone
  } ndma_state_e;

endpackage

// File: rtl/ndma_addr_gen.sv
// Loadable 32-bit address register with an optional +WordBytes step.
// The increment enable is captured together with the address on load, so the
// stepping behaviour stays fixed for the whole transfer.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset
//   load_i      : load load_addr_i / load_inc_i
//   load_addr_i : start address
//   load_inc_i  : 1 = advance by WordBytes on each step, 0 = hold
//   step_i      : advance the address (ignored while loading)
//   addr_o      : current address
module ndma_addr_gen
  import ndma_pkg::*;
#(
  parameter int unsigned WordBytes = NdmaWordBytes
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] load_addr_i,
  input  logic        load_inc_i,
  input  logic        step_i,
  output logic [31:0] addr_o
);

  logic inc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_o <= '0;
      inc_q  <= 1'b0;
    end else if (load_i) begin
      addr_o <= load_addr_i;
      inc_q  <= load_inc_i;
    end else if (step_i && inc_q) begin
      // Wraps silently modulo 2^32.
      addr_o <= addr_o + 32'(WordBytes);
    end
  end

endmodule

// File: rtl/ndma_xfer_ctrl.sv
// Single-channel word-copy DMA controller. Copies len_i words from a source to
// a destination, one word at a time through a one-word buffer: issue a read,
// wait for the data, issue a write, wait for the write manager to go idle.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   start_i               : start pulse (honoured in idle only)
//   src_addr_i/dst_addr_i : start addresses
//   len_i                 : word count (0 completes immediately)
//   src_inc_i/dst_inc_i   : 1 = step address by WordBytes per word
//   abort_i               : stop after the word currently in flight
//   busy_o, done_o        : transfer active, one-cycle completion pulse
//   aborted_o             : last transfer was aborted (sticky until next start)
//   remaining_o           : words not yet written
//   rd_req_o/rd_addr_o, rd_valid_i/rd_data_i       : read manager
//   wr_req_o/wr_addr_o/wr_wdata_o, wr_busy_i       : write manager
module ndma_xfer_ctrl
  import ndma_pkg::*;
#(
  parameter int unsigned LenW      = NdmaLenW,
  parameter int unsigned WordBytes = NdmaWordBytes
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [31:0]     src_addr_i,
  input  logic [31:0]     dst_addr_i,
  input  logic [LenW-1:0] len_i,
  input  logic            src_inc_i,
  input  logic            dst_inc_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            aborted_o,
  output logic [LenW-1:0] remaining_o,
  output logic            rd_req_o,
  output logic [31:0]     rd_addr_o,
  input  logic            rd_valid_i,
  input  logic [31:0]     rd_data_i,
  output logic            wr_req_o,
  output logic [31:0]     wr_addr_o,
  output logic [31:0]     wr_wdata_o,
  input  logic            wr_busy_i
);

  ndma_state_e state_q;
  logic [31:0] data_q;
  logic        abort_q;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic        cfg_load;
  logic        word_done;

  assign cfg_load  = (state_q == StIdle) && start_i;
  assign word_done = (state_q == StWrWait) && !wr_busy_i;

  ndma_addr_gen #(
    .WordBytes (WordBytes)
  ) u_src_addr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (cfg_load),
    .load_addr_i (src_addr_i),
    .load_inc_i  (src_inc_i),
    .step_i      (word_done),
    .addr_o      (src_addr)
  );

  ndma_addr_gen #(
    .WordBytes (WordBytes)
  ) u_dst_addr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (cfg_load),
    .load_addr_i (dst_addr_i),
    .load_inc_i  (dst_inc_i),
    .step_i      (word_done),
    .addr_o      (dst_addr)
  );

  // The issue states each last two cycles: one to launch the registered request
  // and one with the request on the bus. The first read of a transfer is
  // launched straight from start_i so it appears in the next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      aborted_o   <= 1'b0;
      remaining_o <= '0;
      rd_req_o    <= 1'b0;
      rd_addr_o   <= '0;
      wr_req_o    <= 1'b0;
      wr_addr_o   <= '0;
      wr_wdata_o  <= '0;
      data_q      <= '0;
      abort_q     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (busy_o && abort_i) begin
        abort_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            aborted_o   <= 1'b0;
            abort_q     <= 1'b0;
            remaining_o <= len_i;
            busy_o      <= 1'b1;
            if (len_i == '0) begin
              state_q <= StDone;
            end else begin
              rd_req_o  <= 1'b1;
              rd_addr_o <= src_addr_i;
              state_q   <= StRdIssue;
            end
          end
        end

        StRdIssue: begin
          if (rd_req_o) begin
            rd_req_o  <= 1'b0;
            rd_addr_o <= '0;
            state_q   <= StRdWait;
          end else begin
            rd_req_o  <= 1'b1;
            rd_addr_o <= src_addr;
          end
        end

        StRdWait: begin
          if (rd_valid_i) begin
            data_q  <= rd_data_i;
            state_q <= StWrIssue;
          end
        end

        StWrIssue: begin
          if (wr_req_o) begin
            wr_req_o   <= 1'b0;
            wr_addr_o  <= '0;
            wr_wdata_o <= '0;
            state_q    <= StWrWait;
          end else if (!wr_busy_i) begin
            wr_req_o   <= 1'b1;
            wr_addr_o  <= dst_addr;
            wr_wdata_o <= data_q;
          end
        end

        StWrWait: begin
          if (!wr_busy_i) begin
            remaining_o <= remaining_o - LenW'(1);
            if (remaining_o == LenW'(1)) begin
              state_q <= StDone;
            end else if (abort_q || abort_i) begin
              aborted_o <= 1'b1;
              state_q   <= StDone;
            end else begin
              state_q <= StRdIssue;
            end
          end
        end

        StDone: begin
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          abort_q <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ndma_xfer_ctrl.sv
// Directed bench for ndma_xfer_ctrl with a simple read/write manager model.
module tb_ndma_xfer_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] src_addr_i = '0;
  logic [31:0] dst_addr_i = '0;
  logic [15:0] len_i = '0;
  logic        src_inc_i = 1'b0;
  logic        dst_inc_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        aborted_o;
  logic [15:0] remaining_o;
  logic        rd_req_o;
  logic [31:0] rd_addr_o;
  logic        rd_valid_i = 1'b0;
  logic [31:0] rd_data_i = '0;
  logic        wr_req_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_wdata_o;
  logic        wr_busy_i = 1'b0;

  ndma_xfer_ctrl #(
    .LenW      (16),
    .WordBytes (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .src_addr_i  (src_addr_i),
    .dst_addr_i  (dst_addr_i),
    .len_i       (len_i),
    .src_inc_i   (src_inc_i),
    .dst_inc_i   (dst_inc_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .aborted_o   (aborted_o),
    .remaining_o (remaining_o),
    .rd_req_o    (rd_req_o),
    .rd_addr_o   (rd_addr_o),
    .rd_valid_i  (rd_valid_i),
    .rd_data_i   (rd_data_i),
    .wr_req_o    (wr_req_o),
    .wr_addr_o   (wr_addr_o),
    .wr_wdata_o  (wr_wdata_o),
    .wr_busy_i   (wr_busy_i)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int start_cyc;

  // Environment state
  int          blen;
  int          abort_rd;
  int          poke_rd;
  logic        rd_due = 1'b0;
  logic [31:0] rd_pend_addr;
  int          wr_cnt = 0;

  logic [31:0] rd_a[$];
  int          rd_c[$];
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  logic [15:0] wr_rem[$];
  int          wr_c[$];
  int          done_c[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory contents seen by the read manager.
  function automatic logic [31:0] rdata(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]};
  endfunction

  task automatic clear_logs();
    rd_a.delete(); rd_c.delete();
    wr_a.delete(); wr_d.delete(); wr_rem.delete(); wr_c.delete();
    done_c.delete();
  endtask

  // Advance one cycle; sample #1 after the edge and drive the managers.
  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    start_i    = 1'b0;
    abort_i    = 1'b0;
    rd_valid_i = 1'b0;
    if (rd_due) begin
      rd_valid_i = 1'b1;
      rd_data_i  = rdata(rd_pend_addr);
      rd_due     = 1'b0;
    end
    if (wr_cnt > 0) begin
      wr_busy_i = 1'b1;
      wr_cnt--;
    end else begin
      wr_busy_i = 1'b0;
    end
    if (done_o) done_c.push_back(cyc);
    if (rd_req_o) begin
      rd_a.push_back(rd_addr_o);
      rd_c.push_back(cyc);
      rd_due       = 1'b1;
      rd_pend_addr = rd_addr_o;
      if (rd_a.size() == abort_rd) abort_i = 1'b1;
      if (rd_a.size() == poke_rd) begin
        start_i    = 1'b1;
        src_addr_i = 32'hDEAD_0000;
        dst_addr_i = 32'hBEEF_0000;
        len_i      = 16'd1;
      end
    end
    if (wr_req_o) begin
      wr_a.push_back(wr_addr_o);
      wr_d.push_back(wr_wdata_o);
      wr_rem.push_back(remaining_o);
      wr_c.push_back(cyc);
      wr_cnt = blen;
    end
    check_eq("req_excl", 64'(rd_req_o & wr_req_o), 64'd0);
    if (!wr_req_o) check_eq("wr_idle_zero", {wr_addr_o, wr_wdata_o}, 64'd0);
  endtask

  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input logic sinc, input logic dinc, input int bl, input int ab,
                          input int pk);
    clear_logs();
    blen       = bl;
    abort_rd   = ab;
    poke_rd    = pk;
    src_addr_i = src;
    dst_addr_i = dst;
    len_i      = 16'(len);
    src_inc_i  = sinc;
    dst_inc_i  = dinc;
    start_i    = 1'b1;
    start_cyc  = cyc;
    tick();
    check_eq("busy_after_start", 64'(busy_o), 64'd1);
    check_eq("rd_req_latency", 64'(rd_req_o), 64'(len != 0));
    for (int i = 0; i < 600 && done_c.size() == 0; i++) tick();
    for (int i = 0; i < 4; i++) tick();
    check_eq("done_once", 64'(done_c.size()), 64'd1);
    check_eq("idle_busy", 64'(busy_o), 64'd0);
  endtask

  initial begin
    logic [31:0] exp_a[4];

    // Reset state
    tick();
    tick();
    check_eq("rst_ctl", 64'({busy_o, done_o, aborted_o, rd_req_o, wr_req_o}), 64'd0);
    check_eq("rst_remaining", 64'(remaining_o), 64'd0);
    check_eq("rst_addr", {rd_addr_o, wr_addr_o}, 64'd0);
    check_eq("rst_wdata", 64'(wr_wdata_o), 64'd0);
    rst_i = 1'b0;
    tick();

    // Basic three-word copy, both addresses incrementing
    run_xfer(32'h1000, 32'h2000, 3, 1'b1, 1'b1, 2, 0, 0);
    check_eq("t1_rd_cnt", 64'(rd_a.size()), 64'd3);
    check_eq("t1_wr_cnt", 64'(wr_a.size()), 64'd3);
    exp_a = '{32'h1000, 32'h1004, 32'h1008, 32'h0};
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("t1_rd_addr%0d", k), 64'(rd_a[k]), 64'(exp_a[k]));
      check_eq($sformatf("t1_wr_addr%0d", k), 64'(wr_a[k]), 64'(32'h2000 + 32'(4 * k)));
      check_eq($sformatf("t1_wr_data%0d", k), 64'(wr_d[k]), 64'(rdata(exp_a[k])));
      check_eq($sformatf("t1_wr_rem%0d", k), 64'(wr_rem[k]), 64'(3 - k));
    end
    check_eq("t1_first_rd_cyc", 64'(rd_c[0]), 64'(start_cyc + 1));
    check_eq("t1_wr_to_rd", 64'(rd_c[1] - wr_c[0]), 64'd5);
    check_eq("t1_wr_to_done", 64'(done_c[0] - wr_c[2]), 64'd5);
    check_eq("t1_remaining", 64'(remaining_o), 64'd0);
    check_eq("t1_aborted", 64'(aborted_o), 64'd0);

    // Zero-length start
    run_xfer(32'h1000, 32'h2000, 0, 1'b1, 1'b1, 0, 0, 0);
    check_eq("t2_done_cyc", 64'(done_c[0]), 64'(start_cyc + 2));
    check_eq("t2_rd_cnt", 64'(rd_a.size()), 64'd0);
    check_eq("t2_wr_cnt", 64'(wr_a.size()), 64'd0);
    check_eq("t2_remaining", 64'(remaining_o), 64'd0);

    // Fixed destination, slow writes, restart attempt mid-transfer
    run_xfer(32'h8000, 32'h4000, 4, 1'b1, 1'b0, 5, 0, 2);
    check_eq("t3_rd_cnt", 64'(rd_a.size()), 64'd4);
    check_eq("t3_wr_cnt", 64'(wr_a.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t3_rd_addr%0d", k), 64'(rd_a[k]), 64'(32'h8000 + 32'(4 * k)));
      check_eq($sformatf("t3_wr_addr%0d", k), 64'(wr_a[k]), 64'h4000);
      check_eq($sformatf("t3_wr_data%0d", k), 64'(wr_d[k]), 64'(rdata(32'h8000 + 32'(4 * k))));
    end
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("t3_wr_to_rd%0d", k), 64'(rd_c[k+1] - wr_c[k]), 64'd8);
    end
    check_eq("t3_remaining", 64'(remaining_o), 64'd0);

    // Abort during the second read wait of an eight-word copy
    run_xfer(32'h3000, 32'h5000, 8, 1'b1, 1'b1, 1, 2, 0);
    check_eq("t4_rd_cnt", 64'(rd_a.size()), 64'd2);
    check_eq("t4_wr_cnt", 64'(wr_a.size()), 64'd2);
    check_eq("t4_wr_addr1", 64'(wr_a[1]), 64'h5004);
    check_eq("t4_wr_data1", 64'(wr_d[1]), 64'(rdata(32'h3004)));
    check_eq("t4_aborted", 64'(aborted_o), 64'd1);
    check_eq("t4_remaining", 64'(remaining_o), 64'd6);

    // Source address wrap
    run_xfer(32'hFFFF_FFFC, 32'h0100, 2, 1'b1, 1'b1, 0, 0, 0);
    check_eq("t5_rd_addr0", 64'(rd_a[0]), 64'hFFFF_FFFC);
    check_eq("t5_rd_addr1", 64'(rd_a[1]), 64'h0);
    check_eq("t5_wr_addr1", 64'(wr_a[1]), 64'h0104);
    check_eq("t5_wr_data1", 64'(wr_d[1]), 64'(rdata(32'h0)));
    check_eq("t5_wr_to_rd", 64'(rd_c[1] - wr_c[0]), 64'd3);
    check_eq("t5_aborted_cleared", 64'(aborted_o), 64'd0);

    // Reset while waiting on a write
    clear_logs();
    blen       = 5;
    abort_rd   = 0;
    poke_rd    = 0;
    src_addr_i = 32'h6000;
    dst_addr_i = 32'h7000;
    len_i      = 16'd4;
    src_inc_i  = 1'b1;
    dst_inc_i  = 1'b1;
    start_i    = 1'b1;
    tick();
    for (int i = 0; i < 100 && wr_a.size() == 0; i++) tick();
    check_eq("t6_wr_issued", 64'(wr_a.size()), 64'd1);
    tick();
    check_eq("t6_busy_pre", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i      = 1'b0;
    rd_due     = 1'b0;
    wr_cnt     = 0;
    wr_busy_i  = 1'b0;
    rd_valid_i = 1'b0;
    check_eq("t6_rst_ctl", 64'({busy_o, done_o, aborted_o, rd_req_o, wr_req_o}), 64'd0);
    check_eq("t6_rst_remaining", 64'(remaining_o), 64'd0);
    check_eq("t6_rst_addr", {rd_addr_o, wr_addr_o}, 64'd0);
    for (int i = 0; i < 8; i++) tick();
    check_eq("t6_no_done", 64'(done_c.size()), 64'd0);
    check_eq("t6_no_more_rd", 64'(rd_a.size()), 64'd1);

    run_xfer(32'h9000, 32'hA000, 2, 1'b1, 1'b1, 1, 0, 0);
    check_eq("t7_rd_addr1", 64'(rd_a[1]), 64'h9004);
    check_eq("t7_wr_addr0", 64'(wr_a[0]), 64'hA000);
    check_eq("t7_wr_addr1", 64'(wr_a[1]), 64'hA004);
    check_eq("t7_wr_data1", 64'(wr_d[1]), 64'(rdata(32'h9004)));
    check_eq("t7_remaining", 64'(remaining_o), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
